// File: rtl/encoder_pkg.sv
// encoder_pkg: shared widths, drain FSM states and popcount helper for the 8-to-3 encoder
package encoder_pkg;
    localparam int IN_W  = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;
    typedef enum logic {IDLE, DRAIN} state_t;
    function automatic logic [CNT_W-1:0] popcount(input logic [IN_W-1:0] v);
        logic [CNT_W-1:0] p;
        p = '0;
        for (int i = 0; i < IN_W; i++) p = p + {{(CNT_W-1){1'b0}}, v[i]};
        return p;
    endfunction
endpackage

// File: rtl/priority_enc_4to2.sv
// priority_enc_4to2: index of the lowest set bit of a 4-bit vector plus an any-set flag
module priority_enc_4to2 (
    input  logic [3:0] bits,
    output logic [1:0] idx,
    output logic       any
);
    assign any = |bits;
    assign idx = bits[0] ? 2'd0 : bits[1] ? 2'd1 : bits[2] ? 2'd2 : bits[3] ? 2'd3 : 2'd0;
endmodule

// File: rtl/encoder_8to3_drain.sv
// encoder_8to3_drain: captures a request bitmap and drains it as a stream of indices, lowest first
module encoder_8to3_drain
    import encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [IN_W-1:0]  req_bits,
    output logic             req_ready,
    output logic             idx_valid,
    output logic [IDX_W-1:0] idx,
    output logic             idx_last,
    input  logic             idx_ready,
    output logic [CNT_W-1:0] count,
    output logic             zero_err
);
    state_t          state, state_nx;
    logic [IN_W-1:0] pending;
    logic [1:0]      lo_idx, hi_idx;
    logic            lo_any, hi_any, take, beat;

    priority_enc_4to2 u_lo (.bits(pending[3:0]), .idx(lo_idx), .any(lo_any));
    priority_enc_4to2 u_hi (.bits(pending[7:4]), .idx(hi_idx), .any(hi_any));

    assign take = req_ready && req_valid;
    assign beat = idx_valid && idx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            count    <= '0;
            zero_err <= 1'b0;
        end else begin
            state    <= state_nx;
            zero_err <= take && req_bits == '0;
            if (take && req_bits != '0) begin
                pending <= req_bits;
                count   <= popcount(req_bits);
            end else if (beat) begin
                pending <= pending & (pending - 1'b1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = (take && req_bits != '0) ? DRAIN : IDLE;
        else               state_nx = (beat && idx_last) ? IDLE : DRAIN;
    end

    // An empty pending vector (IDLE only) encodes to 0 since hi_any is then clear
    always_comb begin
        req_ready = state == IDLE;
        idx_valid = state == DRAIN;
        idx       = lo_any ? {1'b0, lo_idx} : {hi_any, hi_idx};
        idx_last  = idx_valid && (pending & (pending - 1'b1)) == '0;
    end
endmodule

// File: doc/encoder_8to3_drain.md
# encoder_8to3_drain

Sequential 8-to-3 encoder that accepts an 8-bit one-or-more-hot request vector over a valid/ready handshake and drains it as a stream of 3-bit indices, one set bit per accepted output beat, lowest index first. It is the encode-side counterpart of the 3-to-8 decode path: indices it emits, fed through the 3-to-8 decoder, reconstruct the captured vector bit by bit. It sits between request sources producing bitmaps and consumers that handle one indexed item at a time.

## Interface
Parameters:
- none; widths fixed at 8 in / 3 out, defined in the shared package.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request vector present
- req_bits  input  8  request bitmap; bit i requests index i
- req_ready  output  1  block can accept a vector
- idx_valid  output  1  idx holds a valid index
- idx  output  3  encoded index of lowest pending set bit
- idx_last  output  1  current idx beat is the final bit of the vector
- idx_ready  input  1  consumer accepts current idx beat
- count  output  4  number of set bits in the captured vector (0..8)
- zero_err  output  1  one-cycle pulse: an all-zero vector was accepted

## Operation
- States: IDLE, DRAIN (enum in package).
- IDLE: req_ready=1, idx_valid=0. On req_valid=1 at a rising edge:
  - req_bits != 0: pending <= req_bits, count <= popcount(req_bits), go DRAIN.
  - req_bits == 0: vector consumed, zero_err=1 for the following cycle, pending/count unchanged, stay IDLE.
- DRAIN: req_ready=0, idx_valid=1, idx = index of lowest set bit of pending, idx_last=1 iff pending has exactly one set bit.
  - idx_ready=1 at a rising edge: clear that bit in pending; if idx_last, go IDLE (pending becomes 0).
  - idx_ready=0: hold idx, idx_last, pending stable (no change while stalled).
- count holds its value until the next non-zero capture; reflects the most recent vector.
- req_bits is ignored whenever req_ready=0; no capture in DRAIN.
- idx/idx_valid/idx_last are derived only from registered state (pending, state); no combinational path from any input to any output.

## Timing
- Reset values: state=IDLE, pending=0, req_ready=1, idx_valid=0, idx=0, idx_last=0, count=0, zero_err=0.
- Reset mid-DRAIN: immediate (asynchronous) return to reset values; partially drained vector is discarded, no further beats.
- Capture-to-first-beat latency: 1 cycle (idx_valid high in cycle after acceptance edge).
- Vector with N set bits under continuous idx_ready: N output cycles, then 1 IDLE cycle before next capture is possible; throughput N+1 cycles per vector.
- When idx=0 for an empty pending (only in IDLE), idx_valid=0 qualifies it; idx value is don't-care but drives 0.
- zero_err asserted exactly one cycle, the cycle after the accepting edge.

## Structure
- Package encoder_pkg: state enum (IDLE, DRAIN), IN_W=8, IDX_W=3, CNT_W=4.
- Sub-module priority_enc_4to2: 4-bit input, 2-bit index of lowest set bit, any-valid output. Top instantiates two (lower bits[3:0], upper bits[7:4]); idx = lower valid ? {0, lower idx} : {1, upper idx}. Mirrors the decoder's 1-to-2 / 2-to-4 split.
- Popcount and FSM live in the top module.

## Test plan
- Reset: assert rst mid-operation -> all outputs at reset values within the same cycle, req_ready=1, idx_valid=0.
- Send 8'b1010_0101 with idx_ready=1 -> count=4; idx sequence 0,2,5,7 on consecutive cycles, idx_last only with 7; req_ready returns 1 the cycle after.
- Send 8'b1000_0000 -> single beat idx=7, idx_last=1, count=1.
- Send 8'hFF with idx_ready toggling 1,0,1,0... -> idx 0..7 each held stable through stall cycles, 8 accepted beats total, idx_last on 7.
- Send 8'h00 -> accepted with req_ready=1, zero_err pulses 1 cycle, idx_valid stays 0, count unchanged.
- Drive req_valid=1 with new bits during DRAIN -> ignored; after draining, next vector captured only once req_ready=1; decoding each idx through the 3-to-8 decoder and OR-ing reconstructs the captured vector.
